// File: rtl/step_sequencer.sv
// Multi-channel drum step sequencer core.
// Holds one NUM_STEPS-bit hit pattern per channel, advances a shared step
// counter at a runtime tempo, gates each channel's audio with its pattern
// bit for the current step, and mixes the gated channels into one saturated
// sample. All outputs come straight from registers.
module step_sequencer #(
  parameter int NUM_CH    = 4,
  parameter int NUM_STEPS = 8,
  parameter int AUD_W     = 24,
  parameter int DIV_W     = 26,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ST_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    restart,
  input  logic [DIV_W-1:0]        tempo,
  input  logic                    load,
  input  logic [CH_W-1:0]         load_ch,
  input  logic [NUM_STEPS-1:0]    pattern_in,
  input  logic [NUM_CH-1:0]       mute,
  input  logic [NUM_CH*AUD_W-1:0] aud_in,
  output logic [AUD_W-1:0]        aud_out,
  output logic [ST_W-1:0]         step,
  output logic                    step_pulse,
  output logic [NUM_CH-1:0]       active
);

  // Mixer accumulator is wide enough that summing every channel never wraps.
  localparam int SUM_W = AUD_W + $clog2(NUM_CH) + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-AUD_W+1){1'b0}}, {(AUD_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-AUD_W+1){1'b1}}, {(AUD_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        w_entry;
  logic                        w_term;
  logic                        w_go;
  logic [DIV_W-1:0]            w_tdiv_m1;
  logic [ST_W-1:0]             w_step_inc;
  logic                        w_load_rise;
  logic signed [SUM_W-1:0]     w_sum;

  logic [DIV_W-1:0]            r_tick;
  logic [ST_W-1:0]             r_step;
  logic                        r_pulse;
  logic [NUM_CH-1:0]           r_active;
  logic [AUD_W-1:0]            r_aud;
  logic                        r_load_q;
  logic [NUM_STEPS-1:0]        r_pat [NUM_CH];

  // Sign-extend one channel sample to the accumulator width.
  function automatic logic signed [SUM_W-1:0] f_sext(input logic [AUD_W-1:0] v);
    return {{(SUM_W-AUD_W){v[AUD_W-1]}}, v};
  endfunction

  // Clamp the wide mix into the signed audio range.
  function automatic logic [AUD_W-1:0] f_saturate(input logic signed [SUM_W-1:0] v);
    logic [AUD_W-1:0] res;
    if (v > SAT_MAX) begin
      res = SAT_MAX[AUD_W-1:0];
    end else if (v < SAT_MIN) begin
      res = SAT_MIN[AUD_W-1:0];
    end else begin
      res = v[AUD_W-1:0];
    end
    return res;
  endfunction

  // A tempo of 0 behaves as 1; the live value is used so tempo edits act at once.
  assign w_tdiv_m1   = (tempo == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : tempo - DIV_W'(1);
  assign w_step_inc  = (r_step == ST_W'(NUM_STEPS-1)) ? {ST_W{1'b0}} : r_step + ST_W'(1);
  assign w_load_rise = load & ~r_load_q;
  assign w_go        = (w_state_nxt == ST_RUNNING);

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= ST_STOPPED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus entry and terminal-tick strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_entry     = 1'b0;
    w_term      = 1'b0;
    case (r_state)
      ST_STOPPED: begin
        if (run) begin
          w_state_nxt = ST_RUNNING;
          w_entry     = 1'b1;
        end else begin
          w_state_nxt = ST_STOPPED;
        end
      end
      ST_RUNNING: begin
        if (!run) begin
          w_state_nxt = ST_STOPPED;
        end else begin
          w_state_nxt = ST_RUNNING;
          w_term      = (r_tick >= w_tdiv_m1);
        end
      end
      default: begin
        w_state_nxt = ST_STOPPED;
      end
    endcase
  end

  // Tick counter, step index and step strobe; restart overrides a terminal tick.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_tick  <= {DIV_W{1'b0}};
      r_step  <= {ST_W{1'b0}};
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_go & (w_entry | restart | w_term);
      if (restart) begin
        r_tick <= {DIV_W{1'b0}};
        r_step <= {ST_W{1'b0}};
      end else if (!w_go || w_entry) begin
        r_tick <= {DIV_W{1'b0}};
      end else if (w_term) begin
        r_tick <= {DIV_W{1'b0}};
        r_step <= w_step_inc;
      end else begin
        r_tick <= r_tick + DIV_W'(1);
      end
    end
  end

  // Pattern store: one write per rising edge of load; out-of-range channel is ignored.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_load_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_pat[c] <= {NUM_STEPS{1'b0}};
      end
    end else begin
      r_load_q <= load;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_load_rise && (load_ch == CH_W'(c))) begin
          r_pat[c] <= pattern_in;
        end
      end
    end
  end

  // Per-channel gate from this cycle's step and pattern; cleared when stopping.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_active <= {NUM_CH{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_active[c] <= w_go & r_pat[c][r_step] & ~mute[c];
      end
    end
  end

  // Sum the samples of the gated channels.
  always_comb begin
    w_sum = {SUM_W{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_active[c]) begin
        w_sum = w_sum + f_sext(aud_in[c*AUD_W +: AUD_W]);
      end else begin
        w_sum = w_sum;
      end
    end
  end

  // Registered saturated mix; silent as soon as the sequencer stops.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_aud <= {AUD_W{1'b0}};
    end else if (w_go) begin
      r_aud <= f_saturate(w_sum);
    end else begin
      r_aud <= {AUD_W{1'b0}};
    end
  end

  assign aud_out    = r_aud;
  assign step       = r_step;
  assign step_pulse = r_pulse;
  assign active     = r_active;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: directed scenarios plus a random
// phase, all compared every cycle against a behavioural model.
// Three channels are used so that an out-of-range load_ch value (3) can be
// driven on the 2-bit channel select.
module tb_step_sequencer;

  localparam int NUM_CH    = 3;
  localparam int NUM_STEPS = 8;
  localparam int AUD_W     = 24;
  localparam int DIV_W     = 26;
  localparam int CH_W      = 2;
  localparam int ST_W      = 3;

  logic                    CLOCK_50 = 1'b0;
  logic                    reset;
  logic                    run;
  logic                    restart;
  logic [DIV_W-1:0]        tempo;
  logic                    load;
  logic [CH_W-1:0]         load_ch;
  logic [NUM_STEPS-1:0]    pattern_in;
  logic [NUM_CH-1:0]       mute;
  logic [NUM_CH*AUD_W-1:0] aud_in;
  logic [AUD_W-1:0]        aud_out;
  logic [ST_W-1:0]         step;
  logic                    step_pulse;
  logic [NUM_CH-1:0]       active;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit                   m_run;
  int                   m_tick;
  int                   m_step;
  bit                   m_pulse;
  logic [NUM_CH-1:0]    m_active;
  logic [AUD_W-1:0]     m_aud;
  logic [NUM_STEPS-1:0] m_pat [NUM_CH];
  bit                   m_load_q;

  step_sequencer #(
    .NUM_CH(NUM_CH), .NUM_STEPS(NUM_STEPS), .AUD_W(AUD_W), .DIV_W(DIV_W)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .run       (run),
    .restart   (restart),
    .tempo     (tempo),
    .load      (load),
    .load_ch   (load_ch),
    .pattern_in(pattern_in),
    .mute      (mute),
    .aud_in    (aud_in),
    .aud_out   (aud_out),
    .step      (step),
    .step_pulse(step_pulse),
    .active    (active)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [AUD_W-1:0] sat(input longint s);
    longint hi;
    longint lo;
    longint r;
    hi = (longint'(1) <<< (AUD_W-1)) - 1;
    lo = -(longint'(1) <<< (AUD_W-1));
    r  = (s > hi) ? hi : ((s < lo) ? lo : s);
    return r[AUD_W-1:0];
  endfunction

  task automatic model_reset();
    m_run = 0; m_tick = 0; m_step = 0; m_pulse = 0;
    m_active = '0; m_aud = '0; m_load_q = 0;
    for (int c = 0; c < NUM_CH; c++) m_pat[c] = '0;
  endtask

  // One clock edge of the behaviour: all "next" values from pre-edge state and inputs.
  task automatic model_step();
    int tdiv;
    longint sum;
    logic signed [AUD_W-1:0] smp;
    logic [NUM_CH-1:0] act_n;
    bit entry, term;
    if (!reset) begin
      model_reset();
      return;
    end
    tdiv  = (tempo == 0) ? 1 : int'(tempo);
    entry = !m_run && run;
    term  = m_run && run && (m_tick >= tdiv - 1);
    sum = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      smp = aud_in[c*AUD_W +: AUD_W];
      if (m_active[c]) sum += longint'(smp);
      act_n[c] = run && m_pat[c][m_step] && !mute[c];
    end
    m_aud    = run ? sat(sum) : '0;
    m_active = act_n;
    m_pulse  = run && (entry || restart || term);
    if (restart) begin
      m_step = 0; m_tick = 0;
    end else if (!run || entry) begin
      m_tick = 0;
    end else if (term) begin
      m_tick = 0; m_step = (m_step + 1) % NUM_STEPS;
    end else begin
      m_tick++;
    end
    if (load && !m_load_q && int'(load_ch) < NUM_CH) m_pat[load_ch] = pattern_in;
    m_load_q = load;
    m_run    = run;
  endtask

  task automatic compare_all();
    check_eq("step", step, m_step);
    check_eq("step_pulse", step_pulse, m_pulse);
    check_eq("active", active, m_active);
    check_eq("aud_out", aud_out, m_aud);
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_all_aud(input logic [AUD_W-1:0] v);
    for (int c = 0; c < NUM_CH; c++) aud_in[c*AUD_W +: AUD_W] = v;
  endtask

  task automatic write_pat(input int ch, input logic [NUM_STEPS-1:0] p);
    load_ch = CH_W'(ch); pattern_in = p; load = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
  endtask

  task automatic run_to_step(input int s);
    int guard;
    guard = 0;
    while (m_step != s && guard < 200) begin cyc(); guard++; end
    check_eq("reach_step", m_step, s);
  endtask

  initial begin
    model_reset();
    reset = 1'b0; run = 1'b0; restart = 1'b0; tempo = 26'd4;
    load = 1'b0; load_ch = 2'd0; pattern_in = 8'h00; mute = 3'b000;
    set_all_aud(24'h100000);

    // Reset and idle
    cycles(3);
    reset = 1'b1;
    cycles(20);

    // Step timing and wrap at tempo 4, then tempo 0
    run = 1'b1;
    cyc();
    check_eq("first_pulse", step_pulse, 1);
    cycles(40);
    tempo = 26'd0;
    cycles(10);
    tempo = 26'd4;

    // Load and gating
    run = 1'b0; cyc();
    restart = 1'b1; cyc(); restart = 1'b0;
    load_ch = 2'd2; pattern_in = 8'b0000_0101; load = 1'b1;
    cycles(10);
    load = 1'b0; pattern_in = 8'hFF;
    cycles(2);
    load_ch = 2'd3; load = 1'b1; cyc(); load = 1'b0; cyc();
    run = 1'b1;
    cycles(36);
    mute[2] = 1'b1;
    cycles(36);
    check_eq("muted_active2", active[2], 0);
    mute[2] = 1'b0;

    // Saturation
    for (int c = 0; c < NUM_CH; c++) write_pat(c, 8'hFF);
    cycles(5);
    set_all_aud(24'h700000);
    cycles(2);
    check_eq("sat_pos", aud_out, 24'h7FFFFF);
    set_all_aud(24'h900000);
    cycles(2);
    check_eq("sat_neg", aud_out, 24'h800000);
    mute[2] = 1'b1;
    aud_in[0*AUD_W +: AUD_W] = 24'd5;
    aud_in[1*AUD_W +: AUD_W] = 24'hFFFFFD;
    cycles(3);
    check_eq("mix_5_m3", aud_out, 24'd2);
    mute[2] = 1'b0;

    // Stop, resume, restart on terminal tick
    run_to_step(5);
    run = 1'b0;
    cycles(3);
    check_eq("stop_step", step, 5);
    check_eq("stop_aud", aud_out, 0);
    run = 1'b1;
    cyc();
    check_eq("resume_pulse", step_pulse, 1);
    check_eq("resume_step", step, 5);
    cycles(4);
    check_eq("resume_next", step, 6);
    begin
      int guard;
      guard = 0;
      while (m_tick != 3 && guard < 20) begin cyc(); guard++; end
      check_eq("reach_terminal", m_tick, 3);
    end
    restart = 1'b1; cyc(); restart = 1'b0;
    check_eq("restart_step", step, 0);
    check_eq("restart_pulse", step_pulse, 1);

    // Asynchronous reset mid-run
    run_to_step(3);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("async_step", step, 0);
    check_eq("async_active", active, 0);
    check_eq("async_aud", aud_out, 0);
    run = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(4);
    run = 1'b1;
    cycles(12);
    check_eq("cleared_pat", active, 0);

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      run     = ($urandom_range(0, 99) < 92);
      restart = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 19) == 0) tempo = DIV_W'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) load = ~load;
      load_ch    = CH_W'($urandom_range(0, 3));
      pattern_in = NUM_STEPS'($urandom);
      if ($urandom_range(0, 15) == 0) mute = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++)
        aud_in[c*AUD_W +: AUD_W] = AUD_W'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
